// File: rtl/uart_pkg.sv
// Shared constants, FSM state encodings and the parity helper for the 9-bit UART receiver.
package uart_pkg;

  localparam int DATA_BITS = 9;
  localparam int OS_RATE   = 16;

  // Tick positions inside one bit period; the majority vote is centred on the bit.
  localparam logic [3:0] VOTE_LO  = 4'd6;
  localparam logic [3:0] VOTE_MID = 4'd7;
  localparam logic [3:0] VOTE_HI  = 4'd8;
  localparam logic [3:0] BIT_END  = 4'd15;

  // Receiver FSM encodings.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Parity bit the transmitter should have sent: even parity when odd=0, odd parity when odd=1.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning: 2-flop synchronizer on the serial line and a 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       rxclk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx_in,
  input  logic [3:0] tick_cnt,
  output logic       rx_s,
  output logic       vote
);

  logic [1:0] sync_q;
  logic       samp_lo;
  logic       samp_mid;

  // Two-stage synchronizer; resets to the idle (high) line level.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  assign rx_s = sync_q[1];

  // Capture the first two vote samples; the third is the live rx_s on the decision tick.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      samp_lo  <= 1'b1;
      samp_mid <= 1'b1;
    end else if (sample_tick) begin
      if (tick_cnt == VOTE_LO)  samp_lo  <= rx_s;
      if (tick_cnt == VOTE_MID) samp_mid <= rx_s;
    end
  end

  assign vote = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: start, 9 data bits LSB first, parity, stop.
// Output handshake: a word is offered while rx_valid=1; it is taken on any cycle with
// rx_valid & rx_ready. rx_data and the error flags hold steady until that transfer.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 rxclk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  state_t               state;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_vote;
  logic                 rx_s;
  logic                 vote;
  logic                 frame_done;
  logic                 xfer;
  logic                 accept;

  uart_rx_sampler u_sampler (
    .rxclk       (rxclk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .tick_cnt    (tick_cnt),
    .rx_s        (rx_s),
    .vote        (vote)
  );

  assign rx_busy    = (state != ST_IDLE);
  assign frame_done = sample_tick && (state == ST_STOP) && (tick_cnt == VOTE_HI);
  assign xfer       = rx_valid & rx_ready;
  assign accept     = frame_done & (~rx_valid | xfer);

  // Bit-timing FSM; everything advances only on sample_tick.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= 4'd0;
      bit_idx   <= 4'd0;
      shift_reg <= '0;
      par_vote  <= 1'b0;
    end else if (sample_tick) begin
      case (state)
        ST_IDLE: begin
          // The detection tick itself is count 0, so the next tick is count 1.
          if (!rx_s) begin
            state    <= ST_START;
            tick_cnt <= 4'd1;
          end
        end
        ST_START: begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == VOTE_HI && vote) begin
            state    <= ST_IDLE;
            tick_cnt <= 4'd0;
          end else if (tick_cnt == BIT_END) begin
            state   <= ST_DATA;
            bit_idx <= 4'd0;
          end
        end
        ST_DATA: begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == VOTE_HI) shift_reg[bit_idx] <= vote;
          if (tick_cnt == BIT_END) begin
            if (bit_idx == 4'(DATA_BITS - 1)) state <= ST_PARITY;
            else                              bit_idx <= bit_idx + 4'd1;
          end
        end
        ST_PARITY: begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == VOTE_HI) par_vote <= vote;
          if (tick_cnt == BIT_END) state <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at mid-stop so a back-to-back start bit is not missed.
          if (tick_cnt == VOTE_HI) begin
            state    <= ST_IDLE;
            tick_cnt <= 4'd0;
          end else begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tick_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Output word register: load on completion when free (or being freed), else flag overrun.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (accept) begin
        rx_data       <= shift_reg;
        rx_parity_err <= par_vote ^ parity_of(shift_reg, PARITY_ODD);
        rx_frame_err  <= ~vote;
        rx_valid      <= 1'b1;
      end else if (xfer) begin
        rx_valid <= 1'b0;
      end
      if (frame_done && !accept) rx_overrun <= 1'b1;
      else if (xfer)             rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: sample_tick every 4 rxclk, frames driven tick-aligned.
module tb_uart_rx_os;

  // ---------------- clock / reset ----------------
  logic       rxclk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
  logic [1:0] div = 2'd0;

  always #5 rxclk = ~rxclk;

  always @(posedge rxclk) div <= div + 2'd1;
  assign sample_tick = (div == 2'd3);

  uart_rx_os #(.PARITY_ODD(1'b0)) dut (
    .rxclk         (rxclk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n sample ticks; returns on the negedge just before the next tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge rxclk);
      while (!sample_tick) @(negedge rxclk);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    wait_ticks(n);
  endtask

  task automatic send_body(input logic [8:0] d, input logic par);
    wait_ticks(1);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 9; i++) drive_bit(d[i], 16);
    drive_bit(par, 16);
  endtask

  // A low stop bit is held only through its vote so the idle line is high afterwards.
  task automatic send_frame(input logic [8:0] d, input logic par, input logic stop);
    send_body(d, par);
    if (stop) begin
      drive_bit(1'b1, 16);
    end else begin
      drive_bit(1'b0, 9);
      rx_in = 1'b1;
      wait_ticks(7);
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge rxclk);
    rx_ready = 1'b0;
  endtask

  function automatic logic even_par(input logic [8:0] d);
    return ^d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge rxclk);
    check("rst_valid", 16'(rx_valid), 16'd0);
    check("rst_data", 16'(rx_data), 16'd0);
    check("rst_busy", 16'(rx_busy), 16'd0);
    check("rst_perr", 16'(rx_parity_err), 16'd0);
    check("rst_ferr", 16'(rx_frame_err), 16'd0);
    check("rst_ovr", 16'(rx_overrun), 16'd0);
    reset = 1'b0;

    // Clean frame 0x1A5 with even parity (1).
    send_frame(9'h1A5, 1'b1, 1'b1);
    check("clean_valid", 16'(rx_valid), 16'd1);
    check("clean_data", 16'(rx_data), 16'h1A5);
    check("clean_perr", 16'(rx_parity_err), 16'd0);
    check("clean_ferr", 16'(rx_frame_err), 16'd0);
    pulse_ready();
    check("clean_taken", 16'(rx_valid), 16'd0);

    // Glitch start: low for 3 ticks only.
    wait_ticks(1);
    rx_in = 1'b0;
    wait_ticks(3);
    check("glitch_busy_hi", 16'(rx_busy), 16'd1);
    rx_in = 1'b1;
    wait_ticks(16);
    check("glitch_busy_lo", 16'(rx_busy), 16'd0);
    check("glitch_no_word", 16'(rx_valid), 16'd0);

    // Wrong parity and low stop bit.
    send_frame(9'h0FF, ~even_par(9'h0FF), 1'b0);
    check("err_valid", 16'(rx_valid), 16'd1);
    check("err_data", 16'(rx_data), 16'h0FF);
    check("err_perr", 16'(rx_parity_err), 16'd1);
    check("err_ferr", 16'(rx_frame_err), 16'd1);
    pulse_ready();
    check("err_taken", 16'(rx_valid), 16'd0);

    // Overrun: two frames, nothing consumed.
    send_frame(9'h001, even_par(9'h001), 1'b1);
    send_frame(9'h002, even_par(9'h002), 1'b1);
    check("ovr_valid", 16'(rx_valid), 16'd1);
    check("ovr_data", 16'(rx_data), 16'h001);
    check("ovr_flag", 16'(rx_overrun), 16'd1);
    check("ovr_perr", 16'(rx_parity_err), 16'd0);
    pulse_ready();
    check("ovr_taken", 16'(rx_valid), 16'd0);
    check("ovr_cleared", 16'(rx_overrun), 16'd0);

    // Simultaneous: second completion lands on the same cycle as a transfer.
    send_frame(9'h001, even_par(9'h001), 1'b1);
    send_body(9'h002, even_par(9'h002));
    rx_in = 1'b1;
    wait_ticks(9);
    pulse_ready();
    check("sim_valid", 16'(rx_valid), 16'd1);
    check("sim_data", 16'(rx_data), 16'h002);
    check("sim_ovr", 16'(rx_overrun), 16'd0);
    wait_ticks(7);

    // Reset in the middle of bit 4 of 0x155, with a word still held.
    wait_ticks(1);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'(9'h155 >> i), 16);
    drive_bit(1'b1, 8);
    check("mid_busy_before", 16'(rx_busy), 16'd1);
    reset = 1'b1;
    @(negedge rxclk);
    check("mid_rst_valid", 16'(rx_valid), 16'd0);
    check("mid_rst_data", 16'(rx_data), 16'd0);
    check("mid_rst_busy", 16'(rx_busy), 16'd0);
    check("mid_rst_perr", 16'(rx_parity_err), 16'd0);
    check("mid_rst_ferr", 16'(rx_frame_err), 16'd0);
    check("mid_rst_ovr", 16'(rx_overrun), 16'd0);
    rx_in = 1'b1;
    repeat (3) @(negedge rxclk);
    reset = 1'b0;

    send_frame(9'h0AA, even_par(9'h0AA), 1'b1);
    check("post_valid", 16'(rx_valid), 16'd1);
    check("post_data", 16'(rx_data), 16'h0AA);
    check("post_perr", 16'(rx_parity_err), 16'd0);
    check("post_ferr", 16'(rx_frame_err), 16'd0);
    check("post_ovr", 16'(rx_overrun), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
